unified_mem_arbiter: RTL

Shares one single-port unified instruction/data memory between the processor's instruction-fetch port and its load/store port. This is the structural-hazard resolver the team needs when moving from split memories to a single memory. The block serializes accesses and returns read data plus a one-cycle done pulse to each requester. Data accesses have priority, fetch has a starvation guard, and a per-access timeout covers a hung memory.

---
 rtl/unified_mem_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port unified memory between instruction fetch and load/store.
// Data has priority; fetch is forced after STARVE_LIMIT data grants; each access times out.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                busy
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SC_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TC_W   = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t            state, state_nx;
  logic [SC_W-1:0]   starve_cnt, starve_nx;
  logic [TC_W-1:0]   tmo_cnt, tmo_nx;
  logic              if_elig, d_elig, grant_d, grant_i, timeout_hit, finish;

  logic                if_done_nx, if_err_nx, d_done_nx, d_err_nx;
  logic                mem_req_nx, mem_we_nx, busy_nx;
  logic [DATA_W-1:0]   if_rdata_nx, d_rdata_nx, mem_wdata_nx;
  logic [STRB_W-1:0]   mem_wstrb_nx;
  logic [ADDR_W-1:0]   mem_addr_nx;

  // A requester still showing its done pulse is not eligible, so it cannot be regranted while dropping req
  assign if_elig     = if_req && !if_done;
  assign d_elig      = d_req && !d_done;
  assign grant_d     = (state == IDLE) && d_elig && (!if_elig || starve_cnt != SC_W'(STARVE_LIMIT));
  assign grant_i     = (state == IDLE) && if_elig && !grant_d;
  assign timeout_hit = !mem_ready && (tmo_cnt == TC_W'(TIMEOUT - 1));
  assign finish      = (state != IDLE) && (mem_ready || timeout_hit);

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      if_done    <= 1'b0;
      if_err     <= 1'b0;
      if_rdata   <= '0;
      d_done     <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_wstrb  <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_nx;
      tmo_cnt    <= tmo_nx;
      if_done    <= if_done_nx;
      if_err     <= if_err_nx;
      if_rdata   <= if_rdata_nx;
      d_done     <= d_done_nx;
      d_err      <= d_err_nx;
      d_rdata    <= d_rdata_nx;
      mem_req    <= mem_req_nx;
      mem_we     <= mem_we_nx;
      mem_wstrb  <= mem_wstrb_nx;
      mem_addr   <= mem_addr_nx;
      mem_wdata  <= mem_wdata_nx;
      busy       <= busy_nx;
    end
  end

  // Next state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (grant_d)      state_nx = BUSY_D;
        else if (grant_i) state_nx = BUSY_I;
      end
      BUSY_I, BUSY_D: if (finish) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of outputs and counters
  always_comb begin
    starve_nx    = starve_cnt;
    tmo_nx       = tmo_cnt;
    if_done_nx   = 1'b0;
    if_err_nx    = 1'b0;
    if_rdata_nx  = if_rdata;
    d_done_nx    = 1'b0;
    d_err_nx     = 1'b0;
    d_rdata_nx   = d_rdata;
    mem_req_nx   = mem_req;
    mem_we_nx    = mem_we;
    mem_wstrb_nx = mem_wstrb;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    busy_nx      = (state_nx != IDLE);
    if (grant_d) begin
      mem_req_nx   = 1'b1;
      mem_we_nx    = d_we;
      mem_wstrb_nx = d_wstrb;
      mem_addr_nx  = d_addr;
      mem_wdata_nx = d_wdata;
      tmo_nx       = '0;
      if (!if_req)                                  starve_nx = '0;
      else if (starve_cnt != SC_W'(STARVE_LIMIT))   starve_nx = starve_cnt + SC_W'(1);
    end else if (grant_i) begin
      mem_req_nx   = 1'b1;
      mem_we_nx    = 1'b0;
      mem_wstrb_nx = '0;
      mem_addr_nx  = if_addr;
      mem_wdata_nx = '0;
      tmo_nx       = '0;
      starve_nx    = '0;
    end else if (finish) begin
      mem_req_nx = 1'b0;
      if (state == BUSY_I) begin
        if_done_nx  = 1'b1;
        if_err_nx   = timeout_hit;
        if_rdata_nx = mem_ready ? mem_rdata : '0;
      end else begin
        d_done_nx  = 1'b1;
        d_err_nx   = timeout_hit;
        d_rdata_nx = (mem_ready && !mem_we) ? mem_rdata : '0;
      end
    end else if (state != IDLE) begin
      tmo_nx = tmo_cnt + TC_W'(1);
    end
  end

endmodule
